// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   DMEM_ADDR_W / DMEM_DATA_W : default RAM word-address and data widths
//   arb_state_t               : 2-bit arbiter FSM state
//   cnt_width()               : wait-counter width for a given MAX_WAIT (never 0)
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W = 10;
  localparam int unsigned DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    GRANT_PIPE = 2'd0,
    DBG_ACCESS = 2'd1,
    DBG_RESP   = 2'd2,
    DBG_ACK    = 2'd3
  } arb_state_t;

  // MAX_WAIT=0 would give a zero-width counter; keep one bit that simply stays 0.
  function automatic int unsigned cnt_width(input int unsigned max_wait);
    return (max_wait == 0) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Debug / program-loader request bus into the data-memory arbiter.
//   dbg_req   : request, held with dbg_we/dbg_addr/dbg_wdata stable until dbg_ack
//   dbg_we    : 1 = write, 0 = read
//   dbg_addr  : RAM word address
//   dbg_wdata : write data
//   dbg_ack   : one-cycle completion pulse
//   dbg_rdata : read data, valid with dbg_ack and held until the next debug read completes
// master = debugger side, slave = arbiter side.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
);

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  modport master (
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata
  );

  modport slave (
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata
  );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter used to bound how long a debug request waits.
//   clock, resetn : clock and asynchronous active-low reset
//   inc           : count up by one, stops at LIMIT
//   clr           : synchronous clear, wins over inc
//   count         : current value
module dmem_arbiter_sat_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned LIMIT = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIM)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port synchronous data RAM (1-cycle read latency) between the
// pipeline MEM stage and a debug/program-loader port.
//   clock, resetn       : clock, asynchronous active-low reset
//   pipe_addr/wdata     : MEM-stage address and store data
//   pipe_rden/wren      : MEM-stage read/write enables
//   pipe_rdata          : load data, valid the cycle after pipe_rden
//   pipe_stall          : freeze pipeline; MEM access this cycle is dropped and replayed
//   dbg                 : debug request bus (slave side)
//   ram_address/data    : to RAM address/data
//   ram_rden/wren       : to RAM enables (forced low while resetn=0)
//   ram_q               : RAM read data
// Pipeline accesses pass straight through. A debug access steals one RAM
// cycle (DBG_ACCESS, the only stalled cycle); a pipeline load issued just
// before it is captured so pipe_rdata stays valid through DBG_RESP. A pending
// debug request is granted when the pipeline is idle or after MAX_WAIT
// consecutive busy cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              pipe_rden,
  input  logic              pipe_wren,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  dmem_arbiter_if.slave     dbg,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int unsigned CW = cnt_width(MAX_WAIT);

  arb_state_t        state;
  logic [CW-1:0]     wait_cnt;
  logic              in_grant;
  logic              sel_dbg;
  logic              pipe_active;
  logic              at_limit;
  logic              go;
  logic              wait_inc;
  logic              wait_clr;
  logic              pipe_rd_q;
  logic              hold_valid;
  logic [DATA_W-1:0] hold;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;

  assign in_grant    = (state == GRANT_PIPE);
  assign sel_dbg     = (state == DBG_ACCESS);
  assign pipe_active = pipe_rden | pipe_wren;
  assign at_limit    = (wait_cnt == CW'(MAX_WAIT));
  assign go          = in_grant & dbg.dbg_req & (~pipe_active | at_limit);

  // Counter only moves in GRANT_PIPE; it is already clear when the FSM returns there.
  assign wait_inc = in_grant & dbg.dbg_req & pipe_active & ~go;
  assign wait_clr = in_grant & (go | ~dbg.dbg_req);

  dmem_arbiter_sat_counter #(
    .WIDTH (CW),
    .LIMIT (MAX_WAIT)
  ) u_wait_cnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (wait_inc),
    .clr    (wait_clr),
    .count  (wait_cnt)
  );

  // RAM port mux; enables gated by resetn so a reset mid-access cannot write.
  always_comb begin
    ram_address = pipe_addr;
    ram_data    = pipe_wdata;
    ram_wren    = pipe_wren;
    ram_rden    = pipe_rden;
    if (sel_dbg) begin
      ram_address = dbg.dbg_addr;
      ram_data    = dbg.dbg_wdata;
      ram_wren    = dbg.dbg_we;
      ram_rden    = ~dbg.dbg_we;
    end
    ram_wren = ram_wren & resetn;
    ram_rden = ram_rden & resetn;
  end

  // pipe_stall and dbg_ack are registered: each is set on the transition
  // into the state that owns it, so both are clean Moore outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= GRANT_PIPE;
      pipe_stall <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      pipe_rd_q  <= 1'b0;
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      pipe_rd_q  <= pipe_rden & ~sel_dbg;
      pipe_stall <= 1'b0;
      ack_q      <= 1'b0;
      case (state)
        GRANT_PIPE: begin
          if (go) begin
            state      <= DBG_ACCESS;
            pipe_stall <= 1'b1;
          end
        end
        DBG_ACCESS: begin
          state <= DBG_RESP;
          // ram_q still carries the pipeline load issued in the previous cycle.
          if (pipe_rd_q) begin
            hold       <= ram_q;
            hold_valid <= 1'b1;
          end
        end
        DBG_RESP: begin
          state      <= DBG_ACK;
          ack_q      <= 1'b1;
          hold_valid <= 1'b0;
          if (!dbg.dbg_we) begin
            rdata_q <= ram_q;
          end
        end
        DBG_ACK: begin
          state <= GRANT_PIPE;
        end
        default: begin
          state <= GRANT_PIPE;
        end
      endcase
    end
  end

  assign pipe_rdata    = hold_valid ? hold : ram_q;
  assign dbg.dbg_ack   = ack_q;
  assign dbg.dbg_rdata = rdata_q;

endmodule
